// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared types and constants for the MMU fetch responder
package mmu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_DONE   = 2'd3
    } mmu_state_t;

    localparam int LANES      = 4;
    localparam int ACCESS_CYC = 4;
    localparam int DONE_LAT   = 6;
    localparam int SHORT_LAT  = 2;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mmu_lane_capture.sv
// rtl/mmu_lane_capture.sv - collects SRAM read bytes into a word with per-lane valid tags
module mmu_lane_capture
    import mmu_pkg::*;
(
    input  logic        soc_clk,
    input  logic        MMU_reset,
    input  logic        clear,
    input  logic        rd_en,
    input  logic [1:0]  lane,
    input  logic [7:0]  sram_rdata,
    output logic [31:0] rdata
);

    logic             pend_q;
    logic [1:0]       lane_q;
    logic [7:0]       byte_q [LANES];
    logic [LANES-1:0] valid_q;

    // The SRAM returns data one cycle after the enable, so the lane is remembered
    // and the byte is taken the following cycle whatever the stall input does.
    always_ff @(posedge soc_clk) begin
        if (MMU_reset) begin
            pend_q  <= 1'b0;
            lane_q  <= 2'd0;
            valid_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                byte_q[i] <= 8'h00;
            end
        end else begin
            pend_q <= rd_en;
            lane_q <= lane;
            if (clear) begin
                valid_q <= '0;
            end else if (pend_q) begin
                valid_q[lane_q] <= 1'b1;
                byte_q[lane_q]  <= sram_rdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            rdata[8*i +: 8] = valid_q[i] ? byte_q[i] : 8'h00;
        end
    end

endmodule

// File: rtl/mmu_fetch_responder.sv
// rtl/mmu_fetch_responder.sv - word request to byte-wide SRAM sequencer with range fault
module mmu_fetch_responder
    import mmu_pkg::*;
#(
    parameter int SRAM_ADDR_W = 12
) (
    input  logic                   soc_clk,
    input  logic                   MMU_reset,
    input  logic                   MMU_stall,
    input  logic                   memfetch_start,
    input  logic [31:0]            addr,
    input  logic [3:0]             bits_to_access,
    input  logic                   read_or_write,
    input  logic [31:0]            mem_wdata,
    output logic                   mem_busy,
    output logic                   mem_done,
    output logic                   mem_fault,
    output logic [31:0]            mem_rdata,
    output logic                   sram_en,
    output logic                   sram_we,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [7:0]             sram_wdata,
    input  logic [7:0]             sram_rdata
);

    mmu_state_t  state_q, state_d;
    logic [1:0]  cnt_q;
    logic [31:2] addr_q;
    logic [3:0]  bte_q;
    logic        rw_q;
    logic [31:0] wdata_q;
    logic        short_pend_q;
    logic        fault_q;
    logic        accept;
    logic        short_live;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^addr[1:0];

    // A short (fault or empty-mask) request spends one cycle in IDLE with
    // short_pend_q set, so its mem_done lands in the second cycle after accept.
    assign accept     = (state_q == ST_IDLE) && !short_pend_q && memfetch_start;
    assign short_live = (addr[31:SRAM_ADDR_W] != '0) || (bits_to_access == 4'b0000);

    always_ff @(posedge soc_clk) begin
        if (MMU_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            addr_q       <= '0;
            bte_q        <= 4'b0000;
            rw_q         <= 1'b0;
            wdata_q      <= 32'h0;
            short_pend_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            short_pend_q <= accept && short_live;
            if (accept) begin
                addr_q  <= addr[31:2];
                bte_q   <= bits_to_access;
                rw_q    <= read_or_write;
                wdata_q <= mem_wdata;
                cnt_q   <= 2'd0;
                fault_q <= 1'b0;
            end
            if (short_pend_q) begin
                fault_q <= (addr_q[31:SRAM_ADDR_W] != '0);
            end
            if (state_q == ST_ACCESS && !MMU_stall) begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (short_pend_q) begin
                    state_d = ST_DONE;
                end else if (accept && !short_live) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!MMU_stall && cnt_q == 2'(ACCESS_CYC - 1)) begin
                    state_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (!MMU_stall) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = 8'h00;
        if (state_q == ST_ACCESS) begin
            sram_en    = bte_q[cnt_q] && !MMU_stall;
            sram_we    = rw_q;
            sram_addr  = {addr_q[SRAM_ADDR_W-1:2], cnt_q};
            sram_wdata = lane_byte(wdata_q, cnt_q);
        end
    end

    assign mem_busy  = (state_q != ST_IDLE) || short_pend_q;
    assign mem_done  = (state_q == ST_DONE);
    assign mem_fault = fault_q;

    mmu_lane_capture u_capture (
        .soc_clk    (soc_clk),
        .MMU_reset  (MMU_reset),
        .clear      (accept),
        .rd_en      (sram_en && !sram_we),
        .lane       (cnt_q),
        .sram_rdata (sram_rdata),
        .rdata      (mem_rdata)
    );

endmodule

// File: tb/tb_mmu_fetch_responder.sv
// tb/tb_mmu_fetch_responder.sv - self-checking bench for mmu_fetch_responder
module tb_mmu_fetch_responder;
    import mmu_pkg::*;

    localparam int AW = 12;

    logic          soc_clk;
    logic          MMU_reset;
    logic          MMU_stall;
    logic          memfetch_start;
    logic [31:0]   addr;
    logic [3:0]    bits_to_access;
    logic          read_or_write;
    logic [31:0]   mem_wdata;
    logic          mem_busy;
    logic          mem_done;
    logic          mem_fault;
    logic [31:0]   mem_rdata;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_wdata;
    logic [7:0]    sram_rdata;

    logic [7:0] sram    [0:4095];
    logic [7:0] ref_mem [0:4095];
    logic       load_mem;

    int n_vec;
    int n_bad;

    mmu_fetch_responder #(.SRAM_ADDR_W(AW)) dut (
        .soc_clk        (soc_clk),
        .MMU_reset      (MMU_reset),
        .MMU_stall      (MMU_stall),
        .memfetch_start (memfetch_start),
        .addr           (addr),
        .bits_to_access (bits_to_access),
        .read_or_write  (read_or_write),
        .mem_wdata      (mem_wdata),
        .mem_busy       (mem_busy),
        .mem_done       (mem_done),
        .mem_fault      (mem_fault),
        .mem_rdata      (mem_rdata),
        .sram_en        (sram_en),
        .sram_we        (sram_we),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    function automatic logic [7:0] init_byte(input int i);
        logic [7:0] b;
        b = i[7:0] ^ 8'h5A;
        if (i == 32'h100) b = 8'h11;
        if (i == 32'h101) b = 8'h22;
        if (i == 32'h102) b = 8'h33;
        if (i == 32'h103) b = 8'h44;
        return b;
    endfunction

    always @(posedge soc_clk) begin
        if (load_mem) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_byte(i);
        end else if (sram_en) begin
            if (sram_we) sram[sram_addr] <= sram_wdata;
            else         sram_rdata      <= sram[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: five work cycles that each stalled cycle pushes out, plus DONE.
    function automatic void model(input logic [31:0] a, input logic [3:0] be, input logic rw,
                                  input logic [31:0] wd, input int st_s, input int st_l,
                                  output int e_done, output logic [31:0] e_rd,
                                  output logic e_fault, output int e_en);
        int work;
        int k;
        int idx;
        e_fault = (a[31:AW] != 0);
        e_rd    = 32'h0;
        if (e_fault || be == 4'b0000) begin
            e_done = SHORT_LAT;
            e_en   = 0;
            return;
        end
        work = DONE_LAT - 1;
        k = 0;
        while (work > 0) begin
            k++;
            if (!(st_l > 0 && k >= st_s && k < st_s + st_l)) work--;
        end
        e_done = k + 1;
        e_en   = $countones(be);
        for (int l = 0; l < 4; l++) begin
            idx = (int'(a[AW-1:2]) * 4) + l;
            if (be[l]) begin
                if (rw) ref_mem[idx] = wd[8*l +: 8];
                else    e_rd[8*l +: 8] = ref_mem[idx];
            end
        end
    endfunction

    task automatic run_txn(input logic [31:0] a, input logic [3:0] be, input logic rw,
                           input logic [31:0] wd, input int st_s, input int st_l,
                           input int repulse_at,
                           output int done_cyc, output logic [31:0] rd, output logic fault,
                           output int en_cnt, output int done_cnt, output logic hold_ok,
                           output logic busy_ok);
        done_cyc = 0; rd = 32'h0; fault = 1'b0; en_cnt = 0; done_cnt = 0;
        hold_ok = 1'b1; busy_ok = 1'b1;
        @(posedge soc_clk); #1;
        MMU_reset      = 1'b0;
        MMU_stall      = 1'b0;
        memfetch_start = 1'b1;
        addr           = a;
        bits_to_access = be;
        read_or_write  = rw;
        mem_wdata      = wd;
        for (int k = 1; k <= 40; k++) begin
            @(posedge soc_clk); #1;
            memfetch_start = (repulse_at != 0) && (k == repulse_at || k == repulse_at + 3);
            if (memfetch_start) addr = a ^ 32'h4;
            MMU_stall = (st_l > 0) && (k >= st_s) && (k < st_s + st_l);
            @(negedge soc_clk);
            if (sram_en) en_cnt++;
            if (mem_done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = k;
                    rd       = mem_rdata;
                    fault    = mem_fault;
                end
            end else if (done_cyc != 0 && (mem_rdata !== rd || mem_fault !== fault)) begin
                hold_ok = 1'b0;
            end
            if (done_cyc == 0 && !mem_busy) busy_ok = 1'b0;
            if (done_cyc != 0 && k == done_cyc + 1 && mem_busy) busy_ok = 1'b0;
            if (done_cyc != 0 && k >= done_cyc + 4) break;
        end
        memfetch_start = 1'b0;
        MMU_stall      = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic        rw;
        logic [31:0] wd;
        int          st_s;
        int          st_l;
        int          e_done;
        logic [31:0] e_rd;
        logic        e_fault;
        int          e_en;
    } vec_t;

    vec_t vt [10];

    initial begin
        int          d_cyc, en_c, d_cnt;
        logic [31:0] rd;
        logic        flt, hold_ok, busy_ok;
        int          m_done, m_en;
        logic [31:0] m_rd;
        logic        m_flt;
        logic [31:0] ra;
        logic [3:0]  rbe;
        logic        rrw;
        int          rs, rl;

        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);

        vt[0] = '{32'h0000_0100, 4'hF,    1'b0, 32'h0,        0, 0, 6, 32'h4433_2211, 1'b0, 4};
        vt[1] = '{32'h0000_0008, 4'b0101, 1'b1, 32'hAABB_CCDD, 0, 0, 6, 32'h0,        1'b0, 2};
        vt[2] = '{32'h0001_0000, 4'hF,    1'b0, 32'h0,        1, 2, 2, 32'h0,        1'b1, 0};
        vt[3] = '{32'h0000_0100, 4'hF,    1'b0, 32'h0,        2, 3, 9, 32'h4433_2211, 1'b0, 4};
        vt[4] = '{32'h0000_0008, 4'hF,    1'b0, 32'h0,        0, 0, 6, 32'h51BB_53DD, 1'b0, 4};
        vt[5] = '{32'h0000_0100, 4'h0,    1'b0, 32'h0,        0, 0, 2, 32'h0,        1'b0, 0};
        vt[6] = '{32'h0000_0102, 4'b1010, 1'b0, 32'h0,        0, 0, 6, 32'h4400_2200, 1'b0, 2};
        vt[7] = '{32'h0000_0FFC, 4'hF,    1'b0, 32'h0,        5, 2, 8, 32'hA5A4_A7A6, 1'b0, 4};
        vt[8] = '{32'h0000_1000, 4'h0,    1'b0, 32'h0,        0, 0, 2, 32'h0,        1'b1, 0};
        vt[9] = '{32'h0000_0100, 4'hF,    1'b0, 32'h0,        1, 1, 7, 32'h4433_2211, 1'b0, 4};

        load_mem       = 1'b1;
        MMU_reset      = 1'b1;
        MMU_stall      = 1'b0;
        memfetch_start = 1'b0;
        addr           = 32'h0;
        bits_to_access = 4'h0;
        read_or_write  = 1'b0;
        mem_wdata      = 32'h0;
        repeat (3) @(posedge soc_clk);
        #1 load_mem = 1'b0;
        @(negedge soc_clk);
        chk("rst_busy",  {31'b0, mem_busy},  32'h0);
        chk("rst_done",  {31'b0, mem_done},  32'h0);
        chk("rst_fault", {31'b0, mem_fault}, 32'h0);
        chk("rst_rdata", mem_rdata,          32'h0);
        chk("rst_en",    {31'b0, sram_en},   32'h0);
        chk("rst_we",    {31'b0, sram_we},   32'h0);
        chk("rst_addr",  {20'b0, sram_addr}, 32'h0);
        chk("rst_wdata", {24'b0, sram_wdata}, 32'h0);

        for (int v = 0; v < 10; v++) begin
            model(vt[v].a, vt[v].be, vt[v].rw, vt[v].wd, vt[v].st_s, vt[v].st_l,
                  m_done, m_rd, m_flt, m_en);
            run_txn(vt[v].a, vt[v].be, vt[v].rw, vt[v].wd, vt[v].st_s, vt[v].st_l, 0,
                    d_cyc, rd, flt, en_c, d_cnt, hold_ok, busy_ok);
            chk($sformatf("vec%0d_done_cycle", v), d_cyc, vt[v].e_done);
            chk($sformatf("vec%0d_rdata", v), rd, vt[v].e_rd);
            chk($sformatf("vec%0d_fault", v), {31'b0, flt}, {31'b0, vt[v].e_fault});
            chk($sformatf("vec%0d_en_count", v), en_c, vt[v].e_en);
            chk($sformatf("vec%0d_single_done_hold_busy", v),
                {29'b0, d_cnt == 1, hold_ok, busy_ok}, 32'h7);
        end
        chk("wr_byte_8", {24'b0, sram[12'h008]}, 32'hDD);
        chk("wr_byte_9", {24'b0, sram[12'h009]}, 32'h53);
        chk("wr_byte_a", {24'b0, sram[12'h00A]}, 32'hBB);
        chk("wr_byte_b", {24'b0, sram[12'h00B]}, 32'h51);

        // Abort a read with reset in its third cycle, then issue a request at once.
        @(posedge soc_clk); #1;
        memfetch_start = 1'b1; addr = 32'h100; bits_to_access = 4'hF; read_or_write = 1'b0;
        d_cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge soc_clk); #1;
            memfetch_start = (k == 3);
            MMU_stall      = (k == 3);
            MMU_reset      = (k == 3);
            @(negedge soc_clk);
            if (mem_done) d_cnt++;
        end
        chk("abort_no_done", d_cnt, 0);
        model(32'h8, 4'hF, 1'b0, 32'h0, 0, 0, m_done, m_rd, m_flt, m_en);
        run_txn(32'h8, 4'hF, 1'b0, 32'h0, 0, 0, 0, d_cyc, rd, flt, en_c, d_cnt, hold_ok, busy_ok);
        chk("abort_next_done_cycle", d_cyc, m_done);
        chk("abort_next_rdata", rd, m_rd);

        model(32'h100, 4'hF, 1'b0, 32'h0, 0, 0, m_done, m_rd, m_flt, m_en);
        run_txn(32'h100, 4'hF, 1'b0, 32'h0, 0, 0, 2, d_cyc, rd, flt, en_c, d_cnt, hold_ok, busy_ok);
        chk("repulse_done_cycle", d_cyc, m_done);
        chk("repulse_done_count", d_cnt, 1);
        chk("repulse_rdata", rd, m_rd);
        chk("repulse_en_count", en_c, m_en);

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) != 0) ra[31:AW] = '0;
            rbe = 4'($urandom_range(0, 15));
            rrw = 1'($urandom_range(0, 1));
            rs  = $urandom_range(0, 7);
            rl  = (rs == 0) ? 0 : $urandom_range(0, 3);
            model(ra, rbe, rrw, $urandom, rs, rl, m_done, m_rd, m_flt, m_en);
            run_txn(ra, rbe, rrw, {ref_mem[{ra[AW-1:2], 2'd3}], ref_mem[{ra[AW-1:2], 2'd2}],
                                   ref_mem[{ra[AW-1:2], 2'd1}], ref_mem[{ra[AW-1:2], 2'd0}]},
                    rs, rl, 0, d_cyc, rd, flt, en_c, d_cnt, hold_ok, busy_ok);
            chk($sformatf("rnd%0d_done_cycle", t), d_cyc, m_done);
            chk($sformatf("rnd%0d_rdata", t), rd, m_rd);
            chk($sformatf("rnd%0d_fault", t), {31'b0, flt}, {31'b0, m_flt});
            chk($sformatf("rnd%0d_en_count", t), en_c, m_en);
            chk($sformatf("rnd%0d_single_done_hold_busy", t),
                {29'b0, d_cnt == 1, hold_ok, busy_ok}, 32'h7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no summary expected finish");
        $fatal(1);
    end

endmodule
